// File: rtl/riscv_run_monitor.sv
// riscv_run_monitor: observes the single-cycle RISC-V core's PC and counts RUN
// cycles and retired instructions. It detects program end (PC held for
// HALT_CYCLES consecutive cycles) or a cycle-budget timeout. On halt it
// snapshots NUM_CH watched words and compares them against expected values to
// give a registered per-channel mismatch and a pass/fail verdict.
// Optional feature macro: RUN_MONITOR_JUMP_CNT_EN adds a jump_count output that
// counts taken branches/jumps (a PC change that is not PC+4).
module riscv_run_monitor #(
  parameter int XLEN        = 64,
  parameter int NUM_CH      = 5,
  parameter int HALT_CYCLES = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int CNT_W       = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic [XLEN-1:0]          pc,
  input  logic [NUM_CH*XLEN-1:0]   watch_data,
  input  logic [NUM_CH*XLEN-1:0]   expected,
  output logic [2:0]               state,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count,
  output logic [NUM_CH*XLEN-1:0]   snapshot,
  output logic [NUM_CH-1:0]        mismatch,
  output logic                     pass,
  output logic                     fail,
`ifdef RUN_MONITOR_JUMP_CNT_EN
  output logic [CNT_W-1:0]         jump_count,
`endif
  output logic [XLEN-1:0]          halt_pc
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_e;

  // The stable counter must hold HALT_CYCLES on the halting edge without wrapping.
  localparam int STABLE_W = $clog2(HALT_CYCLES + 1);
  // Timeout compare is done wide enough for both the counter and the budget.
  localparam int CMP_W    = (CNT_W + 1 > 32) ? CNT_W + 1 : 32;

  state_e                   state_q;
  logic [CNT_W-1:0]         cycle_count_q, cycle_count_d;
  logic [CNT_W-1:0]         instr_count_q, instr_count_d;
  logic [NUM_CH*XLEN-1:0]   snapshot_q;
  logic [NUM_CH-1:0]        mismatch_q, mismatch_d;
  logic [XLEN-1:0]          halt_pc_q;
  logic [XLEN-1:0]          prev_pc_q;
  logic [STABLE_W-1:0]      stable_cnt_q, stable_cnt_d;
  logic [CNT_W:0]           cycle_next;
  logic                     pc_changed;
  logic                     halt_det;
  logic                     timeout_det;
`ifdef RUN_MONITOR_JUMP_CNT_EN
  logic [CNT_W-1:0]         jump_count_q, jump_count_d;
`endif

  // Next-state values for RUN: saturating counters, halt and timeout detection, verdict compare.
  always_comb begin
    // NOTE: every always_comb output is assigned before any condition so no latch is inferred.
    pc_changed    = (pc != prev_pc_q);
    cycle_count_d = (cycle_count_q == '1) ? cycle_count_q : cycle_count_q + 1'b1;
    instr_count_d = instr_count_q;
    stable_cnt_d  = stable_cnt_q + 1'b1;
    if (pc_changed) begin
      instr_count_d = (instr_count_q == '1) ? instr_count_q : instr_count_q + 1'b1;
      stable_cnt_d  = '0;
    end
`ifdef RUN_MONITOR_JUMP_CNT_EN
    jump_count_d = jump_count_q;
    if (pc_changed && (pc != (prev_pc_q + XLEN'(4))) && (jump_count_q != '1))
      jump_count_d = jump_count_q + 1'b1;
`endif
    halt_det    = !pc_changed && (stable_cnt_q == STABLE_W'(HALT_CYCLES - 1));
    cycle_next  = {1'b0, cycle_count_q} + 1'b1;
    timeout_det = (CMP_W'(cycle_next) == CMP_W'(MAX_CYCLES));
    mismatch_d  = '0;
    for (int ch = 0; ch < NUM_CH; ch++)
      mismatch_d[ch] = (snapshot_q[ch*XLEN +: XLEN] != expected[ch*XLEN +: XLEN]);
  end

  // Monitor FSM with all observable results held in registers.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      cycle_count_q <= '0;
      instr_count_q <= '0;
      snapshot_q    <= '0;
      mismatch_q    <= '0;
      halt_pc_q     <= '0;
      prev_pc_q     <= '0;
      stable_cnt_q  <= '0;
`ifdef RUN_MONITOR_JUMP_CNT_EN
      jump_count_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            prev_pc_q    <= pc;
            stable_cnt_q <= '0;
            state_q      <= ST_RUN;
          end
        end
        ST_RUN: begin
          cycle_count_q <= cycle_count_d;
          instr_count_q <= instr_count_d;
          stable_cnt_q  <= stable_cnt_d;
          prev_pc_q     <= pc;
`ifdef RUN_MONITOR_JUMP_CNT_EN
          jump_count_q  <= jump_count_d;
`endif
          if (halt_det) begin
            snapshot_q <= watch_data;
            halt_pc_q  <= pc;
            state_q    <= ST_CHECK;
          end else if (timeout_det) begin
            state_q    <= ST_TIMEOUT;
          end
        end
        ST_CHECK: begin
          mismatch_q <= mismatch_d;
          state_q    <= ST_DONE;
        end
        ST_DONE, ST_TIMEOUT: begin
          if (clear) begin
            cycle_count_q <= '0;
            instr_count_q <= '0;
            snapshot_q    <= '0;
            mismatch_q    <= '0;
            halt_pc_q     <= '0;
            stable_cnt_q  <= '0;
`ifdef RUN_MONITOR_JUMP_CNT_EN
            jump_count_q  <= '0;
`endif
            state_q       <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign state       = state_q;
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;
  assign snapshot    = snapshot_q;
  assign mismatch    = mismatch_q;
  assign halt_pc     = halt_pc_q;
  assign pass        = (state_q == ST_DONE) && (mismatch_q == '0);
  assign fail        = ((state_q == ST_DONE) && (mismatch_q != '0)) || (state_q == ST_TIMEOUT);
`ifdef RUN_MONITOR_JUMP_CNT_EN
  assign jump_count  = jump_count_q;
`endif

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Bench for riscv_run_monitor: a history-based model of the monitor is compared
// against the main instance on every falling edge, directed scenarios pin the
// model with hand-computed literals, and a small-counter instance covers
// counter saturation.
module tb_riscv_run_monitor;

  localparam int XLEN  = 64;
  localparam int NCH   = 5;
  localparam int HC    = 4;
  localparam int MAXC  = 20;
  localparam int CNT_W = 32;
  localparam int W     = NCH * XLEN;

  logic             clk = 1'b0;
  logic             reset, enable, clear, enable_b, clear_b;
  logic [XLEN-1:0]  pc;
  logic [W-1:0]     watch, expected;

  logic [2:0]       state, b_state;
  logic [CNT_W-1:0] cycle_count, instr_count;
  logic [3:0]       b_cycle, b_instr;
  logic [W-1:0]     snapshot;
  logic [XLEN-1:0]  b_snapshot;
  logic [NCH-1:0]   mismatch;
  logic [0:0]       b_mismatch;
  logic             pass, fail, b_pass, b_fail;
  logic [XLEN-1:0]  halt_pc, b_halt_pc;
`ifdef RUN_MONITOR_JUMP_CNT_EN
  logic [CNT_W-1:0] jump_count;
  logic [3:0]       b_jump;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  riscv_run_monitor #(.XLEN(XLEN), .NUM_CH(NCH), .HALT_CYCLES(HC), .MAX_CYCLES(MAXC), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .pc(pc),
    .watch_data(watch), .expected(expected), .state(state),
    .cycle_count(cycle_count), .instr_count(instr_count), .snapshot(snapshot),
    .mismatch(mismatch), .pass(pass), .fail(fail),
`ifdef RUN_MONITOR_JUMP_CNT_EN
    .jump_count(jump_count),
`endif
    .halt_pc(halt_pc)
  );

  riscv_run_monitor #(.XLEN(XLEN), .NUM_CH(1), .HALT_CYCLES(HC), .MAX_CYCLES(1000), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b), .clear(clear_b), .pc(pc),
    .watch_data(watch[XLEN-1:0]), .expected(expected[XLEN-1:0]), .state(b_state),
    .cycle_count(b_cycle), .instr_count(b_instr), .snapshot(b_snapshot),
    .mismatch(b_mismatch), .pass(b_pass), .fail(b_fail),
`ifdef RUN_MONITOR_JUMP_CNT_EN
    .jump_count(b_jump),
`endif
    .halt_pc(b_halt_pc)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase 0..4 mirrors the externally visible state numbering. A RUN is kept as
  // the list of PCs seen (start PC first); counts are derived from that list.
  int              m_phase = 0;
  logic [XLEN-1:0] pcs[$];
  logic [W-1:0]    m_snap = '0;
  logic [XLEN-1:0] m_halt_pc = '0;
  logic [NCH-1:0]  m_mis = '0;

  function automatic int m_cycles();
    return (pcs.size() == 0) ? 0 : pcs.size() - 1;
  endfunction

  function automatic int m_changes();
    int c = 0;
    for (int i = 1; i < pcs.size(); i++) if (pcs[i] != pcs[i-1]) c++;
    return c;
  endfunction

  function automatic int m_jumps();
    int c = 0;
    for (int i = 1; i < pcs.size(); i++)
      if (pcs[i] != pcs[i-1] && pcs[i] != pcs[i-1] + 64'd4) c++;
    return c;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; pcs.delete(); m_snap = '0; m_halt_pc = '0; m_mis = '0;
    end else begin
      case (m_phase)
        0: if (enable) begin pcs.delete(); pcs.push_back(pc); m_phase = 1; end
        1: begin
          int  n;
          bit  halted;
          pcs.push_back(pc);
          n = pcs.size() - 1;
          // Halt means the last HC RUN samples each repeated the previous PC.
          halted = (n >= HC);
          if (n >= HC)
            for (int k = 0; k < HC; k++) if (pcs[n-k] != pcs[n-k-1]) halted = 0;
          if (halted) begin
            m_snap = watch; m_halt_pc = pc; m_phase = 2;
          end else if (n == MAXC) begin
            m_phase = 4;
          end
        end
        2: begin
          for (int ch = 0; ch < NCH; ch++)
            m_mis[ch] = (m_snap[ch*XLEN +: XLEN] != expected[ch*XLEN +: XLEN]);
          m_phase = 3;
        end
        default: if (clear) begin
          m_phase = 0; pcs.delete(); m_snap = '0; m_halt_pc = '0; m_mis = '0;
        end
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("state", W'(state), W'(m_phase));
    check("cycle_count", W'(cycle_count), W'(m_cycles()));
    check("instr_count", W'(instr_count), W'(m_changes()));
    check("snapshot", snapshot, m_snap);
    check("mismatch", W'(mismatch), W'(m_mis));
    check("halt_pc", W'(halt_pc), W'(m_halt_pc));
    check("pass", W'(pass), W'(m_phase == 3 && m_mis == '0));
    check("fail", W'(fail), W'((m_phase == 3 && m_mis != '0) || m_phase == 4));
`ifdef RUN_MONITOR_JUMP_CNT_EN
    check("jump_count", W'(jump_count), W'(m_jumps()));
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pack5(input int a, input int b, input int c, input int d, input int e);
    return {64'(e), 64'(d), 64'(c), 64'(b), 64'(a)};
  endfunction

  // Enable at pc=0, then n_inc steps of +4, then hold for HC steps.
  task automatic straight_run(input int n_inc);
    pc = '0; enable = 1'b1; step(); enable = 1'b0;
    for (int i = 1; i <= n_inc; i++) begin pc = 64'(4 * i); step(); end
    for (int i = 0; i < HC; i++) step();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; clear = 1'b0; enable_b = 1'b0; clear_b = 1'b0;
    pc = '0; watch = '0; expected = '0;
    step(); step();
    reset = 1'b0;
    check("reset state", W'(state), W'(0));
    check("reset cycle", W'(cycle_count), W'(0));
    check("reset pass", W'(pass), W'(0));
    check("reset fail", W'(fail), W'(0));

    // Straight run to halt with matching data.
    watch = pack5(10, 20, 30, 40, 50); expected = watch;
    straight_run(8);
    check("straight CHECK", W'(state), W'(2));
    check("straight halt_pc", W'(halt_pc), W'(64'h20));
    step();
    check("straight DONE", W'(state), W'(3));
    check("straight pass", W'(pass), W'(1));
    check("straight fail", W'(fail), W'(0));
    check("straight instr", W'(instr_count), W'(8));
    check("straight cycles", W'(cycle_count), W'(12));
    check("straight mismatch", W'(mismatch), W'(0));
    check("straight snapshot", snapshot, pack5(10, 20, 30, 40, 50));
    clear = 1'b1; step(); clear = 1'b0;
    check("clear idle", W'(state), W'(0));

    // Same run with channel 2 expected value off by one.
    expected = pack5(10, 20, 31, 40, 50);
    straight_run(8); step();
    check("mis DONE", W'(state), W'(3));
    check("mis mask", W'(mismatch), W'(5'b00100));
    check("mis pass", W'(pass), W'(0));
    check("mis fail", W'(fail), W'(1));
    check("mis snap ch2", W'(snapshot[2*XLEN +: XLEN]), W'(30));
    clear = 1'b1; step(); clear = 1'b0;

    // Timeout: PC never holds.
    expected = watch;
    pc = '0; enable = 1'b1; step(); enable = 1'b0;
    for (int i = 1; i <= MAXC - 1; i++) begin pc = pc + 64'd4; step(); end
    check("to still RUN", W'(state), W'(1));
    pc = pc + 64'd4; step();
    check("to state", W'(state), W'(4));
    check("to cycles", W'(cycle_count), W'(20));
    check("to fail", W'(fail), W'(1));
    check("to snapshot", snapshot, '0);
    step(); step();
    check("to sticky", W'(state), W'(4));
    clear = 1'b1; step(); clear = 1'b0;

    // Reset in the middle of RUN, then a fresh program.
    pc = '0; enable = 1'b1; step(); enable = 1'b0;
    for (int i = 0; i < 5; i++) begin pc = pc + 64'd4; step(); end
    reset = 1'b1; step(); reset = 1'b0;
    check("rst mid state", W'(state), W'(0));
    check("rst mid cycles", W'(cycle_count), W'(0));
    check("rst mid instr", W'(instr_count), W'(0));
    pc = 64'h100; enable = 1'b1; step(); enable = 1'b0;
    for (int i = 0; i < 3; i++) begin pc = pc + 64'd4; step(); end
    check("rerun cycles", W'(cycle_count), W'(3));
    check("rerun instr", W'(instr_count), W'(3));
    reset = 1'b1; step(); reset = 1'b0;

    // Halt on the same cycle as the timeout budget; clear in RUN is ignored.
    pc = '0; enable = 1'b1; step(); enable = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      pc = 64'(4 * i); clear = (i >= 3 && i <= 5); step();
    end
    clear = 1'b0;
    check("clear in RUN", W'(state), W'(1));
    for (int i = 0; i < HC - 1; i++) step();
    check("tie pre", W'(cycle_count), W'(19));
    step();
    check("tie CHECK", W'(state), W'(2));
    check("tie cycles", W'(cycle_count), W'(20));
    step();
    check("tie pass", W'(pass), W'(1));
    clear = 1'b1; step(); clear = 1'b0;
    check("tie clr state", W'(state), W'(0));
    check("tie clr halt_pc", W'(halt_pc), W'(0));
    check("tie clr snapshot", snapshot, '0);

    // Taken jumps: 0,4,0x40,0x44,0x8 then held.
    pc = '0; enable = 1'b1; step(); enable = 1'b0;
    pc = 64'h4;  step();
    pc = 64'h40; step();
    pc = 64'h44; step();
    pc = 64'h8;  step();
    for (int i = 0; i < HC; i++) step();
    step();
    check("jmp instr", W'(instr_count), W'(4));
`ifdef RUN_MONITOR_JUMP_CNT_EN
    check("jmp count", W'(jump_count), W'(2));
`endif
    clear = 1'b1; step(); clear = 1'b0;

    // Randomized traffic checked by the model.
    for (int i = 0; i < 2000; i++) begin
      int r;
      reset  = ($urandom_range(0, 99) < 2);
      enable = ($urandom_range(0, 99) < 30);
      clear  = ($urandom_range(0, 99) < 15);
      r = int'($urandom_range(0, 99));
      if (r >= 85)      pc = {$urandom(), $urandom()} & ~64'h3;
      else if (r >= 50) pc = pc + 64'd4;
      if ($urandom_range(0, 9) == 0)
        watch[$urandom_range(0, NCH - 1) * XLEN +: XLEN] = {$urandom(), $urandom()};
      expected = watch;
      if ($urandom_range(0, 4) == 0)
        expected[$urandom_range(0, W - 1)] ^= 1'b1;
      step();
    end
    reset = 1'b0; enable = 1'b0; clear = 1'b0;
    reset = 1'b1; step(); reset = 1'b0;

    // Counter saturation on the 4-bit instance.
    expected = watch;
    pc = '0; enable_b = 1'b1; step(); enable_b = 1'b0;
    for (int i = 0; i < 30; i++) begin pc = pc + 64'd4; step(); end
    check("sat state", W'(b_state), W'(1));
    check("sat cycles", W'(b_cycle), W'(15));
    check("sat instr", W'(b_instr), W'(15));
    for (int i = 0; i < HC; i++) step();
    check("sat CHECK", W'(b_state), W'(2));
    step();
    check("sat pass", W'(b_pass), W'(1));
    check("sat halt_pc", W'(b_halt_pc), W'(64'd120));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
